// File: rtl/clint_pkg.sv
// Shared constants and helpers for the CLINT timer block: register offsets,
// the mtimecmp reset value, register-select encoding and the byte-lane merge.
package clint_pkg;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE     = 3'd0,
    REG_MSIP     = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_MTIME_LO = 3'd4,
    REG_MTIME_HI = 3'd5
  } reg_sel_e;

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] mask_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick.sv
// mtime prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap cycle.
// restart forces the count back to 0 and suppresses that cycle's tick.
module clint_tick
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = 16'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = 16'd0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer with a dbus responder.
// Define CLINT_MSIP_EN to add the MSIP register and drive O_soft_int.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_dbus_req,
  input  logic        I_dbus_we,
  input  logic [31:0] I_dbus_addr,
  input  logic [31:0] I_dbus_data,
  input  logic [3:0]  I_dbus_mask,
  output logic [31:0] O_dbus_data,
  output logic        O_dbus_ready,
  output logic        O_timer_int,
  output logic        O_soft_int
);

  // Bus handshake: I_dbus_req is a valid strobe with no backpressure; every
  // in-window request is accepted in its cycle and answered by exactly one
  // O_dbus_ready pulse on the following cycle, with read data alongside.
  logic        hit;
  logic [15:0] off;
  reg_sel_e    sel;
  logic        wr;
  logic        restart;
  logic        tick;
  logic [31:0] rd_mux;

  logic [63:0] mtime_q,     mtime_d;
  logic [63:0] mtimecmp_q,  mtimecmp_d;
  logic        timer_int_q, timer_int_d;
  logic        ready_q,     ready_d;
  logic [31:0] rdata_q,     rdata_d;

`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;
`endif

  // Address decode and read mux, all from pre-update register values.
  always_comb begin
    hit = I_dbus_req && (I_dbus_addr[31:16] == BASE_ADDR[31:16]);
    off = I_dbus_addr[15:0];
    wr  = hit && I_dbus_we;
    sel = REG_NONE;
    case (off)
`ifdef CLINT_MSIP_EN
      OFF_MSIP:        sel = REG_MSIP;
`endif
      OFF_MTIMECMP_LO: sel = REG_CMP_LO;
      OFF_MTIMECMP_HI: sel = REG_CMP_HI;
      OFF_MTIME_LO:    sel = REG_MTIME_LO;
      OFF_MTIME_HI:    sel = REG_MTIME_HI;
      default:         sel = REG_NONE;
    endcase
    restart = wr && ((sel == REG_MTIME_LO) || (sel == REG_MTIME_HI));

    rd_mux = 32'h0;
    case (sel)
`ifdef CLINT_MSIP_EN
      REG_MSIP:     rd_mux = {31'h0, msip_q};
`endif
      REG_CMP_LO:   rd_mux = mtimecmp_q[31:0];
      REG_CMP_HI:   rd_mux = mtimecmp_q[63:32];
      REG_MTIME_LO: rd_mux = mtime_q[31:0];
      REG_MTIME_HI: rd_mux = mtime_q[63:32];
      default:      rd_mux = 32'h0;
    endcase
  end

  clint_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;

    // A software write to mtime wins over the tick for that cycle.
    if (restart) begin
      if (sel == REG_MTIME_LO)
        mtime_d[31:0]  = mask_merge(mtime_q[31:0], I_dbus_data, I_dbus_mask);
      else
        mtime_d[63:32] = mask_merge(mtime_q[63:32], I_dbus_data, I_dbus_mask);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr && (sel == REG_CMP_LO))
      mtimecmp_d[31:0]  = mask_merge(mtimecmp_q[31:0], I_dbus_data, I_dbus_mask);
    if (wr && (sel == REG_CMP_HI))
      mtimecmp_d[63:32] = mask_merge(mtimecmp_q[63:32], I_dbus_data, I_dbus_mask);

    timer_int_d = (mtime_d >= mtimecmp_d);
    ready_d     = hit;
    rdata_d     = (hit && !I_dbus_we) ? rd_mux : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q     <= 64'h0;
      mtimecmp_q  <= MTIMECMP_RST;
      timer_int_q <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_int_q <= timer_int_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef CLINT_MSIP_EN
  always_comb begin
    msip_d = msip_q;
    if (wr && (sel == REG_MSIP) && I_dbus_mask[0]) msip_d = I_dbus_data[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) msip_q <= 1'b0;
    else      msip_q <= msip_d;
  end

  assign O_soft_int = msip_q;
`else
  assign O_soft_int = 1'b0;
`endif

  assign O_dbus_data  = rdata_q;
  assign O_dbus_ready = ready_q;
  assign O_timer_int  = timer_int_q;

endmodule
